// File: rtl/axil_reg_slice_pkg.sv
// Shared AXI-Lite definitions for the register slice: response codes and
// per-channel packed payload widths.
package axil_reg_slice_pkg;

    localparam int unsigned PROT_WIDTH = 3;
    localparam int unsigned RESP_WIDTH = 2;

    typedef enum logic [RESP_WIDTH-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axil_resp_e;

    function automatic int unsigned aw_width(input int unsigned addr_width);
        return addr_width + PROT_WIDTH;
    endfunction

    function automatic int unsigned w_width(input int unsigned data_width,
                                            input int unsigned strb_width);
        return data_width + strb_width;
    endfunction

    function automatic int unsigned b_width();
        return RESP_WIDTH;
    endfunction

    function automatic int unsigned ar_width(input int unsigned addr_width);
        return addr_width + PROT_WIDTH;
    endfunction

    function automatic int unsigned r_width(input int unsigned data_width);
        return data_width + RESP_WIDTH;
    endfunction

endpackage

// File: rtl/axil_reg_slice_skid.sv
// Two-entry skid buffer for one valid/ready channel; ENABLE=0 degenerates
// to a plain wire-through with no state.
module axil_skid_buf #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ENABLE = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (ENABLE != 0) begin : g_reg
            logic             out_valid_q;
            logic [WIDTH-1:0] out_data_q;
            logic             skid_valid_q;
            logic [WIDTH-1:0] skid_data_q;
            logic             in_fire;
            logic             advance;

            // in_ready comes straight from the skid flop, breaking the ready path.
            assign in_ready  = ~skid_valid_q;
            assign in_fire   = in_valid & ~skid_valid_q;
            assign advance   = ~out_valid_q | out_ready;
            assign out_valid = out_valid_q;
            assign out_data  = out_data_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else if (advance) begin
                    if (skid_valid_q) begin
                        out_valid_q  <= 1'b1;
                        skid_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= in_fire;
                    end
                end else if (in_fire) begin
                    skid_valid_q <= 1'b1;
                end
            end

            // Payload is don't-care while its valid is low, so it carries no reset.
            always_ff @(posedge clk) begin
                if (advance) begin
                    if (skid_valid_q) begin
                        out_data_q <= skid_data_q;
                    end else if (in_fire) begin
                        out_data_q <= in_data;
                    end
                end else if (in_fire) begin
                    skid_data_q <= in_data;
                end
            end
        end else begin : g_bypass
            assign out_data  = in_data;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
        end
    endgenerate

endmodule

// File: rtl/axil_reg_slice.sv
// AXI-Lite register slice between the control-unit master and interconnect
// slave port 0; each channel is an independent optional skid buffer.
module axil_reg_slice
    import axil_reg_slice_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned AW_REG     = 1,
    parameter int unsigned W_REG      = 1,
    parameter int unsigned B_REG      = 1,
    parameter int unsigned AR_REG     = 1,
    parameter int unsigned R_REG      = 1
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int unsigned AW_W = aw_width(ADDR_WIDTH);
    localparam int unsigned W_W  = w_width(DATA_WIDTH, STRB_WIDTH);
    localparam int unsigned B_W  = b_width();
    localparam int unsigned AR_W = ar_width(ADDR_WIDTH);
    localparam int unsigned R_W  = r_width(DATA_WIDTH);

    logic [AW_W-1:0] aw_in, aw_out;
    logic [W_W-1:0]  w_in,  w_out;
    logic [B_W-1:0]  b_in,  b_out;
    logic [AR_W-1:0] ar_in, ar_out;
    logic [R_W-1:0]  r_in,  r_out;

    assign aw_in = {s_axil_awaddr, s_axil_awprot};
    assign {m_axil_awaddr, m_axil_awprot} = aw_out;

    assign w_in = {s_axil_wdata, s_axil_wstrb};
    assign {m_axil_wdata, m_axil_wstrb} = w_out;

    assign b_in = m_axil_bresp;
    assign s_axil_bresp = b_out;

    assign ar_in = {s_axil_araddr, s_axil_arprot};
    assign {m_axil_araddr, m_axil_arprot} = ar_out;

    assign r_in = {m_axil_rdata, m_axil_rresp};
    assign {s_axil_rdata, s_axil_rresp} = r_out;

    axil_skid_buf #(.WIDTH(AW_W), .ENABLE(AW_REG)) u_aw (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (aw_in),
        .in_valid  (s_axil_awvalid),
        .in_ready  (s_axil_awready),
        .out_data  (aw_out),
        .out_valid (m_axil_awvalid),
        .out_ready (m_axil_awready)
    );

    axil_skid_buf #(.WIDTH(W_W), .ENABLE(W_REG)) u_w (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (w_in),
        .in_valid  (s_axil_wvalid),
        .in_ready  (s_axil_wready),
        .out_data  (w_out),
        .out_valid (m_axil_wvalid),
        .out_ready (m_axil_wready)
    );

    // Response channels run from the interconnect back towards the CPU.
    axil_skid_buf #(.WIDTH(B_W), .ENABLE(B_REG)) u_b (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (b_in),
        .in_valid  (m_axil_bvalid),
        .in_ready  (m_axil_bready),
        .out_data  (b_out),
        .out_valid (s_axil_bvalid),
        .out_ready (s_axil_bready)
    );

    axil_skid_buf #(.WIDTH(AR_W), .ENABLE(AR_REG)) u_ar (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (ar_in),
        .in_valid  (s_axil_arvalid),
        .in_ready  (s_axil_arready),
        .out_data  (ar_out),
        .out_valid (m_axil_arvalid),
        .out_ready (m_axil_arready)
    );

    axil_skid_buf #(.WIDTH(R_W), .ENABLE(R_REG)) u_r (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (r_in),
        .in_valid  (m_axil_rvalid),
        .in_ready  (m_axil_rready),
        .out_data  (r_out),
        .out_valid (s_axil_rvalid),
        .out_ready (s_axil_rready)
    );

endmodule

// File: doc/axil_reg_slice.md
Name: axil_reg_slice

Overview:
- AXI-Lite register slice that sits between the z_core control-unit master port and slave port 0 of the AXI-Lite interconnect.
- Breaks all combinational valid/ready and payload paths crossing that boundary, to close 50 MHz timing on MAX10.
- Each of the five channels gets an independent two-entry skid buffer.
- Full throughput: 1 beat/cycle/channel. Ordering within each channel is preserved.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- AW_REG, 1, 1 = skid buffer on AW channel; 0 = wire-through.
- W_REG, 1, same for W.
- B_REG, 1, same for B.
- AR_REG, 1, same for AR.
- R_REG, 1, same for R.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  AW from CPU.
- s_axil_awready  out  1  AW ready to CPU.
- s_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1  W from CPU.
- s_axil_wready  out  1  W ready to CPU.
- s_axil_bresp/bvalid  out  2/1  B to CPU.
- s_axil_bready  in  1  B ready from CPU.
- s_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  AR from CPU.
- s_axil_arready  out  1  AR ready to CPU.
- s_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1  R to CPU.
- s_axil_rready  in  1  R ready from CPU.
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  AW to interconnect.
- m_axil_awready  in  1.
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  W to interconnect.
- m_axil_wready  in  1.
- m_axil_bresp/bvalid  in  2/1  B from interconnect.
- m_axil_bready  out  1.
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  AR to interconnect.
- m_axil_arready  in  1.
- m_axil_rdata/rresp/rvalid  in  DATA_WIDTH/2/1  R from interconnect.
- m_axil_rready  out  1.

Behaviour:
- Channel direction:
  - AW, W, AR: s side to m side.
  - B, R: m side to s side.
- Generic per buffered channel (in/out = source/sink side):
  - State registers: out_valid, out_data, skid_valid, skid_data.
  - in_ready = ~skid_valid, driven straight from a flop.
  - in_fire = in_valid & in_ready.
- Update rules:
  - If ~out_valid | out_ready: if skid_valid, then out_data <= skid_data, out_valid <= 1, skid_valid <= 0. Otherwise out_valid <= in_fire and, on in_fire, out_data <= in_data.
  - Else (output stalled): on in_fire, skid_data <= in_data and skid_valid <= 1.
- Latency: 1 cycle from input handshake to output valid.
- Throughput: back-to-back beats pass at 1/cycle while out_ready stays high.
- Stall handling: when the sink drops ready, at most one extra beat is captured into skid; in_ready then deasserts on the following cycle.
- AXI rule: once out_valid is asserted, payload is held stable until out_ready. Payload is never reordered, duplicated or dropped.
- Simultaneous skid drain and in_valid: in_ready is 0 that cycle, so no accept; the source retries next cycle.
- Bypass (x_REG=0): outputs are continuous assigns from inputs. No state and zero latency for that channel.
- AW and W are independent. The slice imposes no AW/W pairing; the interconnect handles it.
- Reset (rstn low, asynchronous, any time including mid-transaction):
  - out_valid and skid_valid go 0 immediately.
  - All *ready outputs read 1 once skid is empty.
  - Payload registers are not reset (don't-care while valid=0).
  - In-flight beats are discarded; CPU, interconnect and slaves share rstn, so no protocol leak.
- No bresp/rresp modification; response codes pass through unchanged.

Decomposition:
- Shared package: AXI-Lite RESP constants (OKAY=2'b00, EXOKAY, SLVERR, DECERR) and channel payload widths (AW = ADDR_WIDTH+3, W = DATA_WIDTH+STRB_WIDTH, B = 2, AR = ADDR_WIDTH+3, R = DATA_WIDTH+2).
- Sub-module axil_skid_buf: parameters WIDTH and ENABLE, ports clk, rstn, in_data/in_valid/in_ready, out_data/out_valid/out_ready. It is instantiated five times. The top only packs and unpacks channel payloads.

Test Plan:
- Reset then a single AR with araddr=0x0000_0010 and m_arready=1: m_arvalid rises 1 cycle after the s handshake with the same addr; R rdata=0xDEADBEEF reaches s side 1 cycle after m_rvalid.
- Streaming: 8 back-to-back AR beats with m_arready=1: m_arvalid high for 8 consecutive cycles, addresses in order, s_arready never drops.
- Backpressure: m_wready=0 while 3 W beats are offered: 2 are accepted (out + skid), s_wready=0 from the 3rd cycle; after m_wready=1 the beats drain in order with unchanged wdata/wstrb.
- Write to GPIO address 0x0400_1000 with data 0x0000_00A5, strb 0xF: m-side AW and W are seen once each; bresp=OKAY is returned to s side 1 cycle after m_bvalid.
- Async reset mid-burst (rstn low between clock edges, both buffers full): all valids go 0 before the next edge; after release, s_*ready=1 and no stale beat appears.
- AR_REG=0 build: m_arvalid/araddr equal s-side values in the same cycle, other channels still 1-cycle latency.
